// File: rtl/core_pkg.sv
// Shared constants and record types for the dispatch stage and its rename table.
package core_pkg;

    localparam int DISP_WIDTH   = 2;
    localparam int RETIRE_WIDTH = 2;
    localparam int NUM_ROB_ENTS = 32;
    localparam int ROB_IDX_BITS = $clog2(NUM_ROB_ENTS);
    localparam int NUM_AREGS    = 32;
    localparam int AREG_BITS    = $clog2(NUM_AREGS);
    localparam int OPC_BITS     = 7;
    localparam int IMM_BITS     = 32;

    typedef logic [ROB_IDX_BITS-1:0] rob_idx_t;
    typedef logic [ROB_IDX_BITS:0]   rob_cnt_t;
    typedef logic [AREG_BITS-1:0]    areg_t;

    typedef struct packed {
        logic [OPC_BITS-1:0] opcode;
        areg_t               dst_reg;
        areg_t               src1_reg;
        areg_t               src2_reg;
        logic [IMM_BITS-1:0] imm;
    } Decoded_Instr;

    typedef struct packed {
        areg_t dst_reg;
        logic  val;
    } ROB_Entry;

    typedef struct packed {
        logic [OPC_BITS-1:0] op;
        logic [IMM_BITS-1:0] imm;
        rob_idx_t            rob_index;
        rob_idx_t            src1_tag;
        logic                src1_busy;
        rob_idx_t            src2_tag;
        logic                src2_busy;
    } RS_Entry;

    typedef struct packed {
        logic     busy;
        rob_idx_t tag;
    } Reg_Status;

    function automatic rob_cnt_t count_disp(input logic [DISP_WIDTH-1:0] v);
        rob_cnt_t c;
        c = '0;
        for (int i = 0; i < DISP_WIDTH; i++) c = c + rob_cnt_t'(v[i]);
        return c;
    endfunction

    function automatic rob_cnt_t count_ret(input logic [RETIRE_WIDTH-1:0] v);
        rob_cnt_t c;
        c = '0;
        for (int i = 0; i < RETIRE_WIDTH; i++) c = c + rob_cnt_t'(v[i]);
        return c;
    endfunction

endpackage

// File: rtl/reg_status_table.sv
// Architectural register status: busy flag plus tag of the pending producer.
// Reads see this cycle's retires as a bypass; register 0 is never busy.
module reg_status_table
    import core_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst,
    input  logic     [DISP_WIDTH-1:0]       wr_en_i,
    input  areg_t    [DISP_WIDTH-1:0]       wr_reg_i,
    input  rob_idx_t [DISP_WIDTH-1:0]       wr_tag_i,
    input  logic     [RETIRE_WIDTH-1:0]     clr_en_i,
    input  areg_t    [RETIRE_WIDTH-1:0]     clr_reg_i,
    input  rob_idx_t [RETIRE_WIDTH-1:0]     clr_tag_i,
    input  areg_t    [2*DISP_WIDTH-1:0]     rd_reg_i,
    output logic     [2*DISP_WIDTH-1:0]     rd_busy_o,
    output rob_idx_t [2*DISP_WIDTH-1:0]     rd_tag_o
);

    Reg_Status [NUM_AREGS-1:0] status_q;
    Reg_Status [NUM_AREGS-1:0] status_d;

    // Read ports: current state, with busy dropped when the producer retires this cycle.
    always_comb begin
        rd_busy_o = '0;
        rd_tag_o  = '0;
        for (int r = 0; r < 2*DISP_WIDTH; r++) begin
            if (rd_reg_i[r] != '0) begin
                rd_busy_o[r] = status_q[rd_reg_i[r]].busy;
                rd_tag_o[r]  = status_q[rd_reg_i[r]].tag;
                for (int k = 0; k < RETIRE_WIDTH; k++) begin
                    if (clr_en_i[k] && (clr_tag_i[k] == status_q[rd_reg_i[r]].tag))
                        rd_busy_o[r] = 1'b0;
                end
            end
        end
    end

    // Next state: tag-checked clears first, then dispatch writes so dispatch wins;
    // later write ports overwrite earlier ones so the youngest slot wins.
    always_comb begin
        status_d = status_q;
        for (int k = 0; k < RETIRE_WIDTH; k++) begin
            if (clr_en_i[k] && (status_q[clr_reg_i[k]].tag == clr_tag_i[k]))
                status_d[clr_reg_i[k]].busy = 1'b0;
        end
        for (int i = 0; i < DISP_WIDTH; i++) begin
            if (wr_en_i[i] && (wr_reg_i[i] != '0)) begin
                status_d[wr_reg_i[i]].busy = 1'b1;
                status_d[wr_reg_i[i]].tag  = wr_tag_i[i];
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) status_q <= '0;
        else     status_q <= status_d;
    end

endmodule

// File: rtl/dispatch_unit.sv
// In-order dispatch: allocates ROB tags for whole decode groups, renames sources
// through the status table and presents a registered group to ROB and RS.
module dispatch_unit
    import core_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst,
    input  logic         [DISP_WIDTH-1:0]   dec_valid,
    input  Decoded_Instr [DISP_WIDTH-1:0]   dec_instr,
    output logic                            dec_ready,
    output logic         [DISP_WIDTH-1:0]   rob_entry_valid,
    output ROB_Entry     [DISP_WIDTH-1:0]   rob_new_entry,
    output logic         [DISP_WIDTH-1:0]   rs_valid,
    output RS_Entry      [DISP_WIDTH-1:0]   rs_payload,
    input  logic                            rs_ready,
    input  logic         [RETIRE_WIDTH-1:0] ret_valid,
    input  areg_t        [RETIRE_WIDTH-1:0] ret_dst_reg,
    input  rob_idx_t     [RETIRE_WIDTH-1:0] ret_rob_index,
    output rob_cnt_t                        occupancy
);

    rob_idx_t tail_q, tail_d;
    rob_cnt_t occ_q, occ_d;
    logic     [DISP_WIDTH-1:0] rob_valid_q, rob_valid_d;
    ROB_Entry [DISP_WIDTH-1:0] rob_entry_q, rob_entry_d;
    logic     [DISP_WIDTH-1:0] rs_valid_q, rs_valid_d;
    RS_Entry  [DISP_WIDTH-1:0] rs_payload_q, rs_payload_d;

    rob_cnt_t grp_cnt, ret_cnt, free_cnt;
    logic     accept;
    rob_idx_t [DISP_WIDTH-1:0]   slot_tag;
    logic     [DISP_WIDTH-1:0]   wr_en;
    areg_t    [DISP_WIDTH-1:0]   wr_reg;
    areg_t    [2*DISP_WIDTH-1:0] rd_reg;
    logic     [2*DISP_WIDTH-1:0] rd_busy;
    rob_idx_t [2*DISP_WIDTH-1:0] rd_tag;
    ROB_Entry [DISP_WIDTH-1:0]   grp_rob;
    RS_Entry  [DISP_WIDTH-1:0]   grp_rs;

    // Group acceptance: all-or-nothing against start-of-cycle free space.
    always_comb begin
        grp_cnt  = count_disp(dec_valid);
        ret_cnt  = count_ret(ret_valid);
        free_cnt = rob_cnt_t'(NUM_ROB_ENTS) - occ_q;
        accept   = (grp_cnt != '0) && (!(|rs_valid_q) || rs_ready) && (free_cnt >= grp_cnt);
        for (int i = 0; i < DISP_WIDTH; i++) begin
            slot_tag[i]   = tail_q + rob_idx_t'(i);
            wr_en[i]      = accept && dec_valid[i] && (dec_instr[i].dst_reg != '0);
            wr_reg[i]     = dec_instr[i].dst_reg;
            rd_reg[2*i]   = dec_instr[i].src1_reg;
            rd_reg[2*i+1] = dec_instr[i].src2_reg;
        end
    end

    reg_status_table u_status (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_en),
        .wr_reg_i  (wr_reg),
        .wr_tag_i  (slot_tag),
        .clr_en_i  (ret_valid),
        .clr_reg_i (ret_dst_reg),
        .clr_tag_i (ret_rob_index),
        .rd_reg_i  (rd_reg),
        .rd_busy_o (rd_busy),
        .rd_tag_o  (rd_tag)
    );

    // Rename each source; an older slot writing the same register overrides the table.
    always_comb begin
        for (int i = 0; i < DISP_WIDTH; i++) begin
            grp_rob[i].dst_reg  = dec_instr[i].dst_reg;
            grp_rob[i].val      = 1'b0;
            grp_rs[i].op        = dec_instr[i].opcode;
            grp_rs[i].imm       = dec_instr[i].imm;
            grp_rs[i].rob_index = slot_tag[i];
            grp_rs[i].src1_busy = rd_busy[2*i];
            grp_rs[i].src1_tag  = rd_tag[2*i];
            grp_rs[i].src2_busy = rd_busy[2*i+1];
            grp_rs[i].src2_tag  = rd_tag[2*i+1];
            for (int j = 0; j < i; j++) begin
                if (dec_valid[j] && (dec_instr[j].dst_reg != '0)) begin
                    if (dec_instr[j].dst_reg == dec_instr[i].src1_reg) begin
                        grp_rs[i].src1_busy = 1'b1;
                        grp_rs[i].src1_tag  = slot_tag[j];
                    end
                    if (dec_instr[j].dst_reg == dec_instr[i].src2_reg) begin
                        grp_rs[i].src2_busy = 1'b1;
                        grp_rs[i].src2_tag  = slot_tag[j];
                    end
                end
            end
        end
    end

    // Output register: ROB write pulses once per group, RS side holds until taken.
    always_comb begin
        rob_valid_d  = '0;
        rob_entry_d  = rob_entry_q;
        rs_valid_d   = rs_valid_q;
        rs_payload_d = rs_payload_q;
        if (accept) begin
            rob_valid_d  = dec_valid;
            rob_entry_d  = grp_rob;
            rs_valid_d   = dec_valid;
            rs_payload_d = grp_rs;
        end else if (rs_ready) begin
            rs_valid_d = '0;
        end
    end

    // Tail and occupancy bookkeeping; same-cycle retires only affect next cycle's free count.
    always_comb begin
        tail_d = accept ? (tail_q + rob_idx_t'(grp_cnt)) : tail_q;
        occ_d  = occ_q + (accept ? grp_cnt : '0) - ret_cnt;
    end

    // Registers with synchronous reset; in-flight output is dropped on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            tail_q       <= '0;
            occ_q        <= '0;
            rob_valid_q  <= '0;
            rob_entry_q  <= '0;
            rs_valid_q   <= '0;
            rs_payload_q <= '0;
        end else begin
            tail_q       <= tail_d;
            occ_q        <= occ_d;
            rob_valid_q  <= rob_valid_d;
            rob_entry_q  <= rob_entry_d;
            rs_valid_q   <= rs_valid_d;
            rs_payload_q <= rs_payload_d;
        end
    end

    // Retiring more entries than are allocated means the ROB and this stage disagree.
    a_no_retire_underflow: assert property (@(posedge clk) disable iff (rst) ret_cnt <= occ_q)
        else $error("retire count exceeds occupancy");

    assign dec_ready       = accept;
    assign rob_entry_valid = rob_valid_q;
    assign rob_new_entry   = rob_entry_q;
    assign rs_valid        = rs_valid_q;
    assign rs_payload      = rs_payload_q;
    assign occupancy       = occ_q;

endmodule
